// File: rtl/spi_if_burst_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_if_burst_pkg
// Purpose : Shared state encoding, header layout and width derivations for
//           the burst-capable SPI command front end.
// Revision: 1.0 - initial release
// ============================================================================
package spi_if_burst_pkg;

    localparam int HDR_WR_BIT    = 7;
    localparam int HDR_BURST_BIT = 6;
    localparam int HDR_CH_MSB    = 5;
    localparam int BYTE_W        = 8;

    typedef logic [2:0] state_t;

    localparam state_t IDLE     = 3'd0;
    localparam state_t WR_DATA  = 3'd1;
    localparam state_t RD_FETCH = 3'd2;
    localparam state_t RD_WAIT  = 3'd3;
    localparam state_t RD_SHIFT = 3'd4;

    function automatic int calc_n_cs(input int cs_w);
        return 1 << cs_w;
    endfunction

    // Channel and IOC fields share the six low header bits.
    function automatic int calc_ioc_w(input int cs_w);
        return 6 - cs_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_if_burst_slave.sv
`default_nettype none
// ============================================================================
// Module  : spi_slave
// Purpose : Mode-0 SPI byte engine oversampled in the system clock domain.
// Revision: 1.0 - initial release
// ============================================================================
module spi_slave
    import spi_if_burst_pkg::*;
(
    input  logic              i_sys_clk,
    input  logic              i_rst,
    input  logic              i_cs_b_sync,
    input  logic              i_spi_sck,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso,
    output logic              o_rx_valid,
    output logic [BYTE_W-1:0] o_rx_data,
    input  logic              i_tx_valid,
    input  logic [BYTE_W-1:0] i_tx_data
);

    logic [2:0]        r_sck_pipe;
    logic [1:0]        r_mosi_pipe;
    logic [2:0]        r_bit_cnt;
    logic [BYTE_W-1:0] r_rx_shift;
    logic [BYTE_W-1:0] r_tx_shift;
    logic              r_rx_valid;

    logic              w_sck_rise;
    logic              w_sck_fall;
    logic [BYTE_W-1:0] w_rx_byte;

    assign w_sck_rise = r_sck_pipe[1] & ~r_sck_pipe[2];
    assign w_sck_fall = ~r_sck_pipe[1] & r_sck_pipe[2];
    assign w_rx_byte  = {r_rx_shift[BYTE_W-2:0], r_mosi_pipe[1]};

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_sck_pipe  <= '0;
            r_mosi_pipe <= '0;
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_rx_valid  <= 1'b0;
        end else begin
            r_sck_pipe  <= {r_sck_pipe[1:0], i_spi_sck};
            r_mosi_pipe <= {r_mosi_pipe[0], i_spi_mosi};
            r_rx_valid  <= 1'b0;
            if (i_cs_b_sync) begin
                r_bit_cnt <= '0;
            end else if (w_sck_rise) begin
                r_rx_shift <= w_rx_byte;
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_rx_valid <= 1'b1;
                end
            end
            // The falling edge after the 8th bit is skipped so a reply byte
            // loaded right after rx_valid keeps its MSB on MISO.
            if (i_tx_valid) begin
                r_tx_shift <= i_tx_data;
            end else if (w_sck_fall && !i_cs_b_sync && r_bit_cnt != 3'd0) begin
                r_tx_shift <= {r_tx_shift[BYTE_W-2:0], 1'b0};
            end
        end
    end

    assign o_spi_miso = r_tx_shift[BYTE_W-1];
    assign o_rx_valid = r_rx_valid;
    assign o_rx_data  = r_rx_shift;

endmodule
`default_nettype wire

// File: rtl/spi_if_burst.sv
`default_nettype none
// ============================================================================
// Module  : spi_if_burst
// Purpose : SPI command decoder moving multi-byte words to/from register
//           banks, with burst IOC auto-increment and CS-framed abort.
// Revision: 1.0 - initial release
// ============================================================================
module spi_if_burst
    import spi_if_burst_pkg::*;
#(
    parameter  int CS_W       = 2,
    parameter  int DATA_BYTES = 1,
    parameter  int FETCH_LAT  = 2,
    localparam int N_CS       = calc_n_cs(CS_W),
    localparam int IOC_W      = calc_ioc_w(CS_W),
    localparam int DATA_W     = BYTE_W * DATA_BYTES
) (
    input  logic              i_sys_clk,
    input  logic              i_rst,
    output logic [IOC_W-1:0]  o_ioc,
    output logic [N_CS-1:0]   o_cs,
    output logic [DATA_W-1:0] o_data_in,
    input  logic [DATA_W-1:0] i_data_out,
    output logic              o_load_cmd,
    output logic              o_fetch_cmd,
    output logic              o_busy,
    output logic              o_abort,
    input  logic              i_spi_sck,
    output logic              o_spi_miso,
    input  logic              i_spi_mosi,
    input  logic              i_spi_cs_b
);

    localparam logic [1:0] LAST_BYTE = 2'(DATA_BYTES - 1);
    localparam logic [2:0] LAT_END   = 3'(FETCH_LAT);

    logic              r_cs_meta, r_cs_sync, r_cs_dly;
    logic              w_cs_rise;
    logic              w_rx_valid;
    logic [BYTE_W-1:0] w_rx_data;

    state_t            r_state,     w_state_nxt;
    logic [IOC_W-1:0]  r_ioc,       w_ioc_nxt;
    logic [N_CS-1:0]   r_cs,        w_cs_nxt;
    logic [DATA_W-1:0] r_data_in,   w_data_in_nxt;
    logic [DATA_W-1:0] r_tx_word,   w_tx_word_nxt;
    logic [1:0]        r_byte_cnt,  w_byte_cnt_nxt;
    logic [2:0]        r_lat_cnt,   w_lat_cnt_nxt;
    logic              r_burst,     w_burst_nxt;
    logic              r_tx_valid,  w_tx_valid_nxt;
    logic              r_load_cmd,  w_load_nxt;
    logic              r_fetch_cmd, w_fetch_nxt;
    logic              r_abort,     w_abort_nxt;

    assign w_cs_rise = r_cs_sync & ~r_cs_dly;

    spi_slave u_spi_slave (
        .i_sys_clk   (i_sys_clk),
        .i_rst       (i_rst),
        .i_cs_b_sync (r_cs_sync),
        .i_spi_sck   (i_spi_sck),
        .i_spi_mosi  (i_spi_mosi),
        .o_spi_miso  (o_spi_miso),
        .o_rx_valid  (w_rx_valid),
        .o_rx_data   (w_rx_data),
        .i_tx_valid  (r_tx_valid),
        .i_tx_data   (r_tx_word[DATA_W-1 -: BYTE_W])
    );

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_cs_dly    <= 1'b1;
            r_state     <= IDLE;
            r_ioc       <= '0;
            r_cs        <= '0;
            r_data_in   <= '0;
            r_tx_word   <= '0;
            r_byte_cnt  <= '0;
            r_lat_cnt   <= '0;
            r_burst     <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_load_cmd  <= 1'b0;
            r_fetch_cmd <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_cs_meta   <= i_spi_cs_b;
            r_cs_sync   <= r_cs_meta;
            r_cs_dly    <= r_cs_sync;
            r_state     <= w_state_nxt;
            r_ioc       <= w_ioc_nxt;
            r_cs        <= w_cs_nxt;
            r_data_in   <= w_data_in_nxt;
            r_tx_word   <= w_tx_word_nxt;
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_lat_cnt   <= w_lat_cnt_nxt;
            r_burst     <= w_burst_nxt;
            r_tx_valid  <= w_tx_valid_nxt;
            r_load_cmd  <= w_load_nxt;
            r_fetch_cmd <= w_fetch_nxt;
            r_abort     <= w_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ioc_nxt      = r_ioc;
        w_cs_nxt       = r_cs;
        w_data_in_nxt  = r_data_in;
        w_tx_word_nxt  = r_tx_word;
        w_byte_cnt_nxt = r_byte_cnt;
        w_lat_cnt_nxt  = r_lat_cnt;
        w_burst_nxt    = r_burst;
        w_tx_valid_nxt = 1'b0;
        w_load_nxt     = 1'b0;
        w_abort_nxt    = 1'b0;

        // Write-burst increment waits until the load strobe has been seen
        // so o_ioc is stable while o_load_cmd is high.
        if (r_load_cmd && r_burst) begin
            w_ioc_nxt = r_ioc + 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (w_rx_valid) begin
                    w_burst_nxt    = w_rx_data[HDR_BURST_BIT];
                    w_cs_nxt       = N_CS'(1) << w_rx_data[HDR_CH_MSB -: CS_W];
                    w_ioc_nxt      = w_rx_data[IOC_W-1:0];
                    w_byte_cnt_nxt = '0;
                    w_state_nxt    = w_rx_data[HDR_WR_BIT] ? WR_DATA : RD_FETCH;
                end
            end
            WR_DATA: begin
                if (w_rx_valid) begin
                    w_data_in_nxt = (r_data_in << BYTE_W) | DATA_W'(w_rx_data);
                    if (r_byte_cnt == LAST_BYTE) begin
                        w_load_nxt     = 1'b1;
                        w_byte_cnt_nxt = '0;
                        if (!r_burst) begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                    end
                end
            end
            RD_FETCH: begin
                w_lat_cnt_nxt = 3'd1;
                w_state_nxt   = RD_WAIT;
            end
            RD_WAIT: begin
                if (r_lat_cnt == LAT_END) begin
                    w_tx_word_nxt  = i_data_out;
                    w_tx_valid_nxt = 1'b1;
                    w_byte_cnt_nxt = '0;
                    w_lat_cnt_nxt  = '0;
                    w_state_nxt    = RD_SHIFT;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt + 3'd1;
                end
            end
            RD_SHIFT: begin
                if (w_rx_valid) begin
                    if (r_byte_cnt == LAST_BYTE) begin
                        w_byte_cnt_nxt = '0;
                        if (r_burst) begin
                            w_ioc_nxt   = r_ioc + 1'b1;
                            w_state_nxt = RD_FETCH;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                        w_tx_word_nxt  = r_tx_word << BYTE_W;
                        w_tx_valid_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // CS release wins after the byte of this cycle has been processed.
        if (w_cs_rise) begin
            if ((r_state == WR_DATA && w_byte_cnt_nxt != 2'd0) || r_state == RD_WAIT) begin
                w_abort_nxt = 1'b1;
            end
            w_state_nxt    = IDLE;
            w_tx_valid_nxt = 1'b0;
            w_byte_cnt_nxt = '0;
            w_lat_cnt_nxt  = '0;
        end
    end

    assign w_fetch_nxt = (w_state_nxt == RD_FETCH);

    assign o_ioc       = r_ioc;
    assign o_cs        = r_cs;
    assign o_data_in   = r_data_in;
    assign o_load_cmd  = r_load_cmd;
    assign o_fetch_cmd = r_fetch_cmd;
    assign o_busy      = (r_state != IDLE);
    assign o_abort     = r_abort;

endmodule
`default_nettype wire
